linebuf_bank_arbiter: RTL and testbench
=======================================

Name: linebuf_bank_arbiter

Overview:
- Shares the two 64x30 line-buffer SRAM banks between two requesters: the scaler controller's real-time video port and a low-priority debug/host access port.
- Video always wins: its per-bank cs/we/addr/din pass through with zero added latency.
- A single debug transaction (read or write to one bank) is slotted into any cycle where the video side leaves the target bank idle.
- Sits between the scaler controller and the SRAM macros. Provides bounded-wait timeout and a contention statistic.

Parameters:
- AW, 6, SRAM address width
- DW, 30, SRAM data width ({R,G,B} 10b each)
- TIMEOUT, 64, max cycles a debug request waits for a free bank slot before abort (≥1)
- CNT_W, 16, width of blocked-cycle statistic counter

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- i_v_cs1, i_v_we1  in  1,1  video bank-1 select/write enable
- i_v_addr1  in  AW  video bank-1 address
- i_v_din1  in  DW  video bank-1 write data
- i_v_cs2, i_v_we2  in  1,1  video bank-2 select/write enable
- i_v_addr2  in  AW  video bank-2 address
- i_v_din2  in  DW  video bank-2 write data
- o_v_dout1, o_v_dout2  out  DW  bank read data returned to video (direct from SRAM)
- o_cs1, o_we1  out  1,1  SRAM bank-1 controls
- o_addr1  out  AW  SRAM bank-1 address
- o_din1  out  DW  SRAM bank-1 write data
- i_dout1  in  DW  SRAM bank-1 read data (combinational read, valid same cycle)
- o_cs2, o_we2, o_addr2, o_din2, i_dout2  as bank 1, for bank 2
- i_dbg_req  in  1  debug request; accepted when o_dbg_ready=1
- i_dbg_we  in  1  1=write, 0=read
- i_dbg_bank  in  1  0=bank1, 1=bank2
- i_dbg_addr  in  AW  debug address
- i_dbg_wdata  in  DW  debug write data
- o_dbg_ready  out  1  arbiter idle, can accept
- o_dbg_done  out  1  one-cycle completion pulse
- o_dbg_err  out  1  valid with done; 1=timed out, no access performed
- o_dbg_rdata  out  DW  read result, held until next accept
- o_blk_cnt  out  CNT_W  saturating count of cycles a pending debug access was blocked by video

Behaviour:
- FSM states IDLE, WAIT_GNT, RESP. Reset → IDLE.
- Reset values: o_dbg_done=0, o_dbg_err=0, o_dbg_rdata=0, o_blk_cnt=0, wait counter=0, latched request fields=0. o_dbg_ready=1 (it is exactly state==IDLE).
- IDLE: if i_dbg_req, latch we/bank/addr/wdata, clear wait counter, go WAIT_GNT.
- WAIT_GNT, when the target bank video cs=0 this cycle (grant):
  - Drive that bank with the latched access: cs=1, we=latched we, addr, din.
  - For a read, register i_doutX into o_dbg_rdata at the clock edge.
  - Go RESP with err=0.
- WAIT_GNT, when the target bank video cs=1 (blocked):
  - Video fields drive SRAM unchanged.
  - Increment wait counter and o_blk_cnt (saturate at all-ones).
  - If wait counter==TIMEOUT-1 on this blocked cycle, go RESP with err=1. The access is dropped and o_dbg_rdata keeps its prior value.
- RESP: o_dbg_done=1 for exactly one cycle, o_dbg_err per outcome, then IDLE. i_dbg_req is ignored in WAIT_GNT/RESP.
- Latency: a debug access completes 2 cycles after accept at best (grant in the first WAIT_GNT cycle, done the next). Worst case is TIMEOUT+1 cycles to done.
- SRAM mux per bank, combinational: if video cs=1, output video cs/we/addr/din; else if debug is granted to this bank, output debug fields; else cs=0, we=0, with addr/din from video. The non-target bank is never touched by debug.
- o_v_dout1/2 = i_dout1/2 unconditionally.
- Video timing is never altered: zero cycles added, zero cycles stolen.
- Async reset mid-transaction: immediate return to IDLE with no done pulse. o_blk_cnt and o_dbg_rdata are cleared.

Test Plan:
- Video idle, debug write bank1 addr 5 data 0x3FF00FFC → o_cs1=1, o_we1=1, o_addr1=5 in the cycle after accept. Done pulse next cycle with err=0. Bank2 cs stays 0.
- Video idle, bank2 preloaded addr 9=0x1234567, debug read bank2 addr 9 → o_dbg_rdata=0x1234567 at done, err=0.
- Video cs2 held 1 for 10 cycles, debug read bank2 → 10 blocked cycles, o_blk_cnt=10, grant in cycle 11. Video addr/din on bank2 unchanged throughout.
- Video cs1 held 1 indefinitely, TIMEOUT=64, debug write bank1 → done with err=1 exactly 65 cycles after accept. SRAM bank1 is never written with debug data. o_blk_cnt=64.
- Video active on bank1 only, debug targets bank2 → granted on the first WAIT_GNT cycle. Bank1 video pass-through is bit-exact.
- rstn deasserted during WAIT_GNT → o_dbg_ready=1 and all outputs at reset values immediately. No done pulse after release.

Source files
------------

// File: rtl/linebuf_bank_arbiter_if.sv
// ---------------------------------------------------------------------------
// linebuf_bank_arbiter_if
// Debug/host access port of the line-buffer bank arbiter.
//   i_dbg_req    request, taken when o_dbg_ready=1
//   i_dbg_we     1=write, 0=read
//   i_dbg_bank   0=bank1, 1=bank2
//   i_dbg_addr   word address inside the bank
//   i_dbg_wdata  write data
//   o_dbg_ready  arbiter idle, a request is accepted this cycle
//   o_dbg_done   one-cycle completion pulse
//   o_dbg_err    valid with done; 1 = timed out, nothing was accessed
//   o_dbg_rdata  last read result, held until the next accept
// master = host side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface linebuf_bank_arbiter_if #(
    parameter int AW = 6,
    parameter int DW = 30
);
    logic          i_dbg_req;
    logic          i_dbg_we;
    logic          i_dbg_bank;
    logic [AW-1:0] i_dbg_addr;
    logic [DW-1:0] i_dbg_wdata;
    logic          o_dbg_ready;
    logic          o_dbg_done;
    logic          o_dbg_err;
    logic [DW-1:0] o_dbg_rdata;

    modport master (
        output i_dbg_req, i_dbg_we, i_dbg_bank, i_dbg_addr, i_dbg_wdata,
        input  o_dbg_ready, o_dbg_done, o_dbg_err, o_dbg_rdata
    );

    modport slave (
        input  i_dbg_req, i_dbg_we, i_dbg_bank, i_dbg_addr, i_dbg_wdata,
        output o_dbg_ready, o_dbg_done, o_dbg_err, o_dbg_rdata
    );
endinterface

// File: rtl/linebuf_bank_arbiter.sv
// ---------------------------------------------------------------------------
// linebuf_bank_arbiter
// Shares two line-buffer SRAM banks between the real-time video port and a
// low-priority debug port. Video requests pass straight through with no added
// latency; a single debug access is slotted into a cycle where video leaves
// the target bank idle, with a bounded wait (TIMEOUT) before it is aborted.
// Ports:
//   clk, rstn                      clock, async active-low reset
//   i_v_cs/we/addr/din{1,2}        video bank requests
//   o_v_dout{1,2}                  bank read data back to video
//   o_cs/we/addr/din{1,2}          SRAM bank controls
//   i_dout{1,2}                    SRAM read data (combinational)
//   dbg                            debug port (slave side)
//   o_blk_cnt                      saturating count of video-blocked cycles
// ---------------------------------------------------------------------------
module linebuf_bank_arbiter #(
    parameter int AW      = 6,
    parameter int DW      = 30,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_v_cs1,
    input  logic                  i_v_we1,
    input  logic [AW-1:0]         i_v_addr1,
    input  logic [DW-1:0]         i_v_din1,
    input  logic                  i_v_cs2,
    input  logic                  i_v_we2,
    input  logic [AW-1:0]         i_v_addr2,
    input  logic [DW-1:0]         i_v_din2,
    output logic [DW-1:0]         o_v_dout1,
    output logic [DW-1:0]         o_v_dout2,
    output logic                  o_cs1,
    output logic                  o_we1,
    output logic [AW-1:0]         o_addr1,
    output logic [DW-1:0]         o_din1,
    input  logic [DW-1:0]         i_dout1,
    output logic                  o_cs2,
    output logic                  o_we2,
    output logic [AW-1:0]         o_addr2,
    output logic [DW-1:0]         o_din2,
    input  logic [DW-1:0]         i_dout2,
    linebuf_bank_arbiter_if.slave dbg,
    output logic [CNT_W-1:0]      o_blk_cnt
);

    // Wait counter must reach TIMEOUT-1 and hold its increment without wrap.
    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_GNT, RESP} state_t;

    state_t        state;
    logic          lat_we;
    logic          lat_bank;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [WCW-1:0] wait_cnt;
    logic          done_q;
    logic          err_q;
    logic [DW-1:0] rdata_q;
    logic          tgt_busy;
    logic          gnt1;
    logic          gnt2;

    // Debug only gets a bank in a cycle where video leaves that bank idle.
    assign tgt_busy = lat_bank ? i_v_cs2 : i_v_cs1;
    assign gnt1     = (state == WAIT_GNT) && !lat_bank && !i_v_cs1;
    assign gnt2     = (state == WAIT_GNT) &&  lat_bank && !i_v_cs2;

    // Per-bank SRAM mux: video first, then a granted debug access; when
    // neither is active the bank is deselected but addr/din follow video.
    assign o_cs1   = i_v_cs1 | gnt1;
    assign o_we1   = i_v_cs1 ? i_v_we1 : (gnt1 & lat_we);
    assign o_addr1 = gnt1 ? lat_addr  : i_v_addr1;
    assign o_din1  = gnt1 ? lat_wdata : i_v_din1;

    assign o_cs2   = i_v_cs2 | gnt2;
    assign o_we2   = i_v_cs2 ? i_v_we2 : (gnt2 & lat_we);
    assign o_addr2 = gnt2 ? lat_addr  : i_v_addr2;
    assign o_din2  = gnt2 ? lat_wdata : i_v_din2;

    assign o_v_dout1 = i_dout1;
    assign o_v_dout2 = i_dout2;

    assign dbg.o_dbg_ready = (state == IDLE);
    assign dbg.o_dbg_done  = done_q;
    assign dbg.o_dbg_err   = err_q;
    assign dbg.o_dbg_rdata = rdata_q;

    // Debug transaction FSM. done/err are registered on entry to RESP so the
    // pulse lines up with the RESP cycle and lasts exactly one cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            lat_we    <= 1'b0;
            lat_bank  <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            wait_cnt  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            o_blk_cnt <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (dbg.i_dbg_req) begin
                        lat_we    <= dbg.i_dbg_we;
                        lat_bank  <= dbg.i_dbg_bank;
                        lat_addr  <= dbg.i_dbg_addr;
                        lat_wdata <= dbg.i_dbg_wdata;
                        wait_cnt  <= '0;
                        state     <= WAIT_GNT;
                    end
                end
                WAIT_GNT: begin
                    if (!tgt_busy) begin
                        if (!lat_we) begin
                            rdata_q <= lat_bank ? i_dout2 : i_dout1;
                        end
                        done_q <= 1'b1;
                        state  <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                        if (o_blk_cnt != {CNT_W{1'b1}}) begin
                            o_blk_cnt <= o_blk_cnt + CNT_W'(1);
                        end
                        // Abort on the TIMEOUT-th blocked cycle; rdata untouched.
                        if (wait_cnt == WAIT_LAST) begin
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                            state  <= RESP;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_linebuf_bank_arbiter.sv
// ---------------------------------------------------------------------------
// tb_linebuf_bank_arbiter
// Bench for linebuf_bank_arbiter: SRAM bank models, a transaction-level
// reference model, a per-cycle compare process, directed scenarios with
// literal expectations and a randomized phase.
// ---------------------------------------------------------------------------
module tb_linebuf_bank_arbiter;

    localparam int AW      = 6;
    localparam int DW      = 30;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 16;
    localparam int MAXBLK  = (1 << CNT_W) - 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          v_cs1, v_we1, v_cs2, v_we2;
    logic [AW-1:0] v_addr1, v_addr2;
    logic [DW-1:0] v_din1, v_din2;
    logic [DW-1:0] o_v_dout1, o_v_dout2;
    logic          o_cs1, o_we1, o_cs2, o_we2;
    logic [AW-1:0] o_addr1, o_addr2;
    logic [DW-1:0] o_din1, o_din2;
    logic [DW-1:0] sram_dout1, sram_dout2;
    logic [CNT_W-1:0] o_blk_cnt;

    linebuf_bank_arbiter_if #(.AW(AW), .DW(DW)) dbg_if ();

    linebuf_bank_arbiter #(
        .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .i_v_cs1   (v_cs1),
        .i_v_we1   (v_we1),
        .i_v_addr1 (v_addr1),
        .i_v_din1  (v_din1),
        .i_v_cs2   (v_cs2),
        .i_v_we2   (v_we2),
        .i_v_addr2 (v_addr2),
        .i_v_din2  (v_din2),
        .o_v_dout1 (o_v_dout1),
        .o_v_dout2 (o_v_dout2),
        .o_cs1     (o_cs1),
        .o_we1     (o_we1),
        .o_addr1   (o_addr1),
        .o_din1    (o_din1),
        .i_dout1   (sram_dout1),
        .o_cs2     (o_cs2),
        .o_we2     (o_we2),
        .o_addr2   (o_addr2),
        .o_din2    (o_din2),
        .i_dout2   (sram_dout2),
        .dbg       (dbg_if),
        .o_blk_cnt (o_blk_cnt)
    );

    always #5 clk = ~clk;

    // SRAM banks driven by the DUT: synchronous write, combinational read.
    bit [DW-1:0] sram1 [64];
    bit [DW-1:0] sram2 [64];

    always @(posedge clk) begin
        if (o_cs1 && o_we1) sram1[o_addr1] <= o_din1;
        if (o_cs2 && o_we2) sram2[o_addr2] <= o_din2;
    end

    assign sram_dout1 = sram1[o_addr1];
    assign sram_dout2 = sram2[o_addr2];

    // Reference model: one outstanding debug transaction, how many cycles it
    // has been blocked, and the memory contents it should see.
    bit [DW-1:0] mmem1 [64];
    bit [DW-1:0] mmem2 [64];
    logic          m_busy, m_resp, m_err, m_we, m_bank;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    int            m_waited, m_blk;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_busy   <= 1'b0;
            m_resp   <= 1'b0;
            m_err    <= 1'b0;
            m_we     <= 1'b0;
            m_bank   <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_rdata  <= '0;
            m_waited <= 0;
            m_blk    <= 0;
        end else begin
            m_resp <= 1'b0;
            if (v_cs1 && v_we1) mmem1[v_addr1] <= v_din1;
            if (v_cs2 && v_we2) mmem2[v_addr2] <= v_din2;
            if (!m_resp) begin
                if (!m_busy) begin
                    if (dbg_if.i_dbg_req) begin
                        m_busy   <= 1'b1;
                        m_we     <= dbg_if.i_dbg_we;
                        m_bank   <= dbg_if.i_dbg_bank;
                        m_addr   <= dbg_if.i_dbg_addr;
                        m_wdata  <= dbg_if.i_dbg_wdata;
                        m_waited <= 0;
                    end
                end else if (!(m_bank ? v_cs2 : v_cs1)) begin
                    m_busy <= 1'b0;
                    m_resp <= 1'b1;
                    m_err  <= 1'b0;
                    if (m_we) begin
                        if (m_bank) mmem2[m_addr] <= m_wdata;
                        else        mmem1[m_addr] <= m_wdata;
                    end else begin
                        m_rdata <= m_bank ? mmem2[m_addr] : mmem1[m_addr];
                    end
                end else begin
                    m_waited <= m_waited + 1;
                    if (m_blk < MAXBLK) m_blk <= m_blk + 1;
                    if (m_waited + 1 == TIMEOUT) begin
                        m_busy <= 1'b0;
                        m_resp <= 1'b1;
                        m_err  <= 1'b1;
                    end
                end
            end
        end
    end

    // Expected SRAM-side values for the current cycle.
    logic          e_g1, e_g2, e_cs1, e_cs2, e_we1, e_we2;
    logic [AW-1:0] e_addr1, e_addr2;
    logic [DW-1:0] e_din1, e_din2;

    assign e_g1    = m_busy && !m_bank && !v_cs1;
    assign e_g2    = m_busy &&  m_bank && !v_cs2;
    assign e_cs1   = v_cs1 || e_g1;
    assign e_cs2   = v_cs2 || e_g2;
    assign e_we1   = v_cs1 ? v_we1 : (e_g1 && m_we);
    assign e_we2   = v_cs2 ? v_we2 : (e_g2 && m_we);
    assign e_addr1 = e_g1 ? m_addr : v_addr1;
    assign e_addr2 = e_g2 ? m_addr : v_addr2;
    assign e_din1  = e_g1 ? m_wdata : v_din1;
    assign e_din2  = e_g2 ? m_wdata : v_din2;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("cs1",    64'(o_cs1),     64'(e_cs1));
            checkOutput("we1",    64'(o_we1),     64'(e_we1));
            checkOutput("addr1",  64'(o_addr1),   64'(e_addr1));
            checkOutput("din1",   64'(o_din1),    64'(e_din1));
            checkOutput("cs2",    64'(o_cs2),     64'(e_cs2));
            checkOutput("we2",    64'(o_we2),     64'(e_we2));
            checkOutput("addr2",  64'(o_addr2),   64'(e_addr2));
            checkOutput("din2",   64'(o_din2),    64'(e_din2));
            checkOutput("vdout1", 64'(o_v_dout1), 64'(mmem1[e_addr1]));
            checkOutput("vdout2", 64'(o_v_dout2), 64'(mmem2[e_addr2]));
            checkOutput("ready",  64'(dbg_if.o_dbg_ready), 64'(!m_busy && !m_resp));
            checkOutput("done",   64'(dbg_if.o_dbg_done),  64'(m_resp));
            if (m_resp) checkOutput("err", 64'(dbg_if.o_dbg_err), 64'(m_err));
            checkOutput("rdata",  64'(dbg_if.o_dbg_rdata), 64'(m_rdata));
            checkOutput("blkcnt", 64'(o_blk_cnt), 64'(m_blk));
        end
    end

    // Drive one cycle of inputs; video we/addr/din are random filler.
    task automatic applyStimulus(input bit cs1, input bit cs2, input bit req, input bit dwe,
                                 input bit dbank, input logic [AW-1:0] daddr,
                                 input logic [DW-1:0] dwdata);
        v_cs1   = cs1;
        v_we1   = 1'($urandom_range(0, 1));
        v_addr1 = AW'($urandom_range(0, 63));
        v_din1  = DW'($urandom);
        v_cs2   = cs2;
        v_we2   = 1'($urandom_range(0, 1));
        v_addr2 = AW'($urandom_range(0, 63));
        v_din2  = DW'($urandom);
        dbg_if.i_dbg_req   = req;
        dbg_if.i_dbg_we    = dwe;
        dbg_if.i_dbg_bank  = dbank;
        dbg_if.i_dbg_addr  = daddr;
        dbg_if.i_dbg_wdata = dwdata;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        step();
    endtask

    // Full debug access with video idle on both banks, ending back in IDLE.
    task automatic doTxn(input bit dwe, input bit dbank, input logic [AW-1:0] daddr,
                         input logic [DW-1:0] dwdata);
        applyStimulus(1'b0, 1'b0, 1'b1, dwe, dbank, daddr, dwdata);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        step();
    endtask

    int pct [5] = '{0, 25, 50, 90, 100};

    initial begin
        int done_at;
        logic err_at;

        v_cs1 = 0; v_we1 = 0; v_addr1 = '0; v_din1 = '0;
        v_cs2 = 0; v_we2 = 0; v_addr2 = '0; v_din2 = '0;
        dbg_if.i_dbg_req = 0; dbg_if.i_dbg_we = 0; dbg_if.i_dbg_bank = 0;
        dbg_if.i_dbg_addr = '0; dbg_if.i_dbg_wdata = '0;

        step();
        chk_en = 1'b1;
        checkOutput("rst_ready", 64'(dbg_if.o_dbg_ready), 64'd1);
        checkOutput("rst_done",  64'(dbg_if.o_dbg_done),  64'd0);
        checkOutput("rst_err",   64'(dbg_if.o_dbg_err),   64'd0);
        checkOutput("rst_rdata", 64'(dbg_if.o_dbg_rdata), 64'd0);
        checkOutput("rst_blk",   64'(o_blk_cnt),          64'd0);
        rstn = 1'b1;
        step();

        $display("[TB] write bank1 with video idle");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd5, 30'h3FF00FFC);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        checkOutput("t1_cs1",   64'(o_cs1),   64'd1);
        checkOutput("t1_we1",   64'(o_we1),   64'd1);
        checkOutput("t1_addr1", 64'(o_addr1), 64'd5);
        checkOutput("t1_din1",  64'(o_din1),  64'h3FF00FFC);
        checkOutput("t1_cs2",   64'(o_cs2),   64'd0);
        step();
        checkOutput("t1_done",  64'(dbg_if.o_dbg_done), 64'd1);
        checkOutput("t1_err",   64'(dbg_if.o_dbg_err),  64'd0);
        checkOutput("t1_cs2b",  64'(o_cs2),             64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        step();

        $display("[TB] read bank2 preloaded by video");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        v_cs2 = 1'b1; v_we2 = 1'b1; v_addr2 = 6'd9; v_din2 = 30'h1234567;
        step();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd9, '0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        checkOutput("t2_cs2",   64'(o_cs2),   64'd1);
        checkOutput("t2_we2",   64'(o_we2),   64'd0);
        checkOutput("t2_addr2", 64'(o_addr2), 64'd9);
        step();
        checkOutput("t2_done",  64'(dbg_if.o_dbg_done),  64'd1);
        checkOutput("t2_err",   64'(dbg_if.o_dbg_err),   64'd0);
        checkOutput("t2_rdata", 64'(dbg_if.o_dbg_rdata), 64'h1234567);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        step();

        $display("[TB] bank2 blocked by video for 10 cycles");
        pulseReset();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'd20, '0);
        step();
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
            step();
        end
        checkOutput("t3_blk", 64'(o_blk_cnt), 64'd10);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        checkOutput("t3_cs2",   64'(o_cs2),   64'd1);
        checkOutput("t3_addr2", 64'(o_addr2), 64'd20);
        step();
        checkOutput("t3_done", 64'(dbg_if.o_dbg_done), 64'd1);
        checkOutput("t3_err",  64'(dbg_if.o_dbg_err),  64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        step();

        $display("[TB] bank1 held by video until timeout");
        pulseReset();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'd7, 30'h2AAAAAAA);
        step();
        done_at = -1;
        err_at  = 1'b0;
        for (int n = 1; n <= 80; n++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
            if (dbg_if.o_dbg_done && done_at < 0) begin
                done_at = n;
                err_at  = dbg_if.o_dbg_err;
            end
            step();
        end
        checkOutput("t4_done_cycle", 64'(done_at), 64'd65);
        checkOutput("t4_err",        64'(err_at),  64'd1);
        checkOutput("t4_blk",        64'(o_blk_cnt), 64'd64);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        step();

        $display("[TB] video on bank1, debug write to bank2");
        pulseReset();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 6'd12, 30'h0ABCDEF1);
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        checkOutput("t5_cs2",   64'(o_cs2),   64'd1);
        checkOutput("t5_we2",   64'(o_we2),   64'd1);
        checkOutput("t5_addr2", 64'(o_addr2), 64'd12);
        checkOutput("t5_din2",  64'(o_din2),  64'h0ABCDEF1);
        checkOutput("t5_cs1",   64'(o_cs1),   64'd1);
        checkOutput("t5_we1",   64'(o_we1),   64'(v_we1));
        checkOutput("t5_addr1", 64'(o_addr1), 64'(v_addr1));
        checkOutput("t5_din1",  64'(o_din1),  64'(v_din1));
        step();
        checkOutput("t5_done", 64'(dbg_if.o_dbg_done), 64'd1);
        checkOutput("t5_err",  64'(dbg_if.o_dbg_err),  64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        step();

        $display("[TB] reset while waiting for a grant");
        doTxn(1'b1, 1'b0, 6'd3, 30'h155);
        doTxn(1'b0, 1'b0, 6'd3, '0);
        checkOutput("t6_rdata_pre", 64'(dbg_if.o_dbg_rdata), 64'h155);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd3, '0);
        step();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
            step();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        rstn = 1'b0;
        #1;
        checkOutput("t6_ready", 64'(dbg_if.o_dbg_ready), 64'd1);
        checkOutput("t6_done",  64'(dbg_if.o_dbg_done),  64'd0);
        checkOutput("t6_err",   64'(dbg_if.o_dbg_err),   64'd0);
        checkOutput("t6_rdata", 64'(dbg_if.o_dbg_rdata), 64'd0);
        checkOutput("t6_blk",   64'(o_blk_cnt),          64'd0);
        step();
        rstn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
            checkOutput("t6_no_done", 64'(dbg_if.o_dbg_done), 64'd0);
            step();
        end

        $display("[TB] randomized traffic");
        for (int b = 0; b < 15; b++) begin
            for (int c = 0; c < 200; c++) begin
                applyStimulus($urandom_range(0, 99) < pct[b % 5],
                              $urandom_range(0, 99) < pct[(b * 3 + 1) % 5],
                              $urandom_range(0, 2) == 0,
                              1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)),
                              AW'($urandom_range(0, 63)),
                              DW'($urandom));
                step();
            end
        end

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        step();
        chk_en = 1'b0;
        for (int a = 0; a < 64; a++) begin
            checkOutput("mem1", 64'(sram1[a]), 64'(mmem1[a]));
            checkOutput("mem2", 64'(sram2[a]), 64'(mmem2[a]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
